rock_regelaar: RTL and testbench
================================

// Module: rock_regelaar
// PURPOSE
//   Rocking-intensity controller; sits directly downstream of the stress-delta stage.
//   Consumes the per-sample stressLaag flag and counts "stress dropped" events over fixed windows.
//   After each window it steps rock_level up, holds it, or steps it down, and drives motor enable.
//   When the level reaches 0 the block reports the baby calm and stops the motor.
// PARAMETERS
//   LEVEL_W      3   width of rock_level
//   MAX_LEVEL    7   saturation ceiling for rock_level (<= 2**LEVEL_W-1)
//   START_LEVEL  3   level loaded on start (1..MAX_LEVEL)
//   WINDOW       16  tick strobes per observation window (>= 2)
//   THRESH       4   stressLaag hits per window needed for a "good" window (1..WINDOW)
//   CALM_WINDOWS 2   consecutive good windows before one level step down
//   FAIL_LIMIT   3   consecutive failed windows at MAX_LEVEL before alarm (ROCK_ALARM_EN only)
// PORTS
//   clk         in   1        system clock, all state on rising edge
//   r           in   1        reset, asynchronous, active-high
//   start       in   1        1-cycle pulse: begin rocking session
//   stop        in   1        1-cycle pulse: abort session, return to IDLE
//   tick        in   1        1-cycle sensor-sample strobe, >= 2 cycles apart
//   stressLaag  in   1        stress-decreased flag, valid when tick=1, stable across posedge
//   rock_level  out  LEVEL_W  current rocking intensity to motor driver
//   motor_en    out  1        motor drive enable
//   calm        out  1        level: session ended with level 0
//   window_done out  1        1-cycle pulse in DECIDE cycle
//   alarm       out  1        sticky stress alarm (ROCK_ALARM_EN only)
// BEHAVIOUR
// - Reset (async, immediate): state IDLE; rock_level=0, motor_en=0, calm=0, window_done=0, alarm=0; counters 0.
// - States: IDLE, OBSERVE, DECIDE, CALM. Outputs are registered.
// - stop has highest priority: from any state -> IDLE next cycle; counters, level and outputs cleared, alarm cleared.
// - IDLE/CALM: start (without stop) -> OBSERVE; level=START_LEVEL, motor_en=1, calm=0, counters 0.
// - OBSERVE: start ignored.
//   - On tick: win_cnt++; hits++ if stressLaag=1.
//   - On the tick that makes win_cnt==WINDOW: -> DECIDE (hits include that tick).
//   - win_cnt and hits never exceed WINDOW.
// - DECIDE (exactly 1 cycle, window_done=1); any tick in this cycle is dropped.
//   - Good (hits>=THRESH): fail_cnt=0, good_cnt++.
//     - If good_cnt reaches CALM_WINDOWS: level-1, good_cnt=0.
//     - If the new level is 0: -> CALM, motor_en=0, calm=1.
//   - Fail: good_cnt=0, level=min(level+1,MAX_LEVEL).
//     - fail_cnt++ only if level was already MAX_LEVEL; saturates at FAIL_LIMIT.
//   - Otherwise -> OBSERVE with win_cnt=hits=0.
// - Latency: window_done one cycle after the closing tick; new rock_level visible the cycle after DECIDE.
// - rock_level never exceeds MAX_LEVEL and never wraps below 0.
// - stressLaag is ignored when tick=0; the input must be a clean registered level (no clock-gated pulse).
// CONFIGURATION
// - `ROCK_ALARM_EN defined:
//   - alarm set in DECIDE when fail_cnt reaches FAIL_LIMIT.
//   - alarm is sticky through good windows; cleared only by r or stop.
// - Not defined: no fail_cnt, alarm port tied to 0, no alarm logic.
// STRUCTURE
// - rock_pkg:
//   - state enum (IDLE, OBSERVE, DECIDE, CALM)
//   - window-counter width function clog2(WINDOW+1)
//   - DECIDE outcome encoding (GOOD/FAIL)
// - Sub-module rock_venster:
//   - tick/hit counting with window-complete strobe, synchronous clear input.
//   - FSM, level arithmetic and alarm stay in top.
// TESTING (default parameters)
// 1. start; 32 ticks all stressLaag=1 -> window_done pulses twice; rock_level 3 -> 2 after 2nd DECIDE.
// 2. start; 16 ticks stressLaag=0 -> rock_level 3 -> 4; 5 more failed windows -> saturates at 7.
// 3. Level 1 plus 2 good windows -> rock_level 0, motor_en=0, calm=1; start -> level 3, calm=0.
// 4. r asserted mid-OBSERVE, between edges -> all outputs 0 immediately; IDLE after release.
// 5. start and stop in the same cycle in IDLE -> stays IDLE; stop during DECIDE -> IDLE, window_done=0 next cycle.
// 6. ROCK_ALARM_EN at level 7: 3 failed windows -> alarm=1; a good window keeps alarm=1; stop clears it.

Source files
------------

// File: rtl/rock_pkg.sv
// Shared types and helpers for the rocking-intensity controller (rock_regelaar).
// The optional stress alarm is enabled with `ROCK_ALARM_EN.
package rock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OBSERVE = 2'd1,
    DECIDE  = 2'd2,
    CALM    = 2'd3
  } rock_state_t;

  typedef enum logic {
    GOOD = 1'b0,
    FAIL = 1'b1
  } rock_outcome_t;

  // Bits needed to hold a counter that must reach maxVal itself.
  function automatic int cntWidth(input int maxVal);
    return $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/rock_venster.sv
// Observation-window counter: counts tick strobes and stressLaag hits.
// Flags the tick that completes the window; cleared synchronously by the controller.
module rock_venster #(
  parameter int WINDOW = 16,
  parameter int WIN_W  = 5
) (
  input  logic             clk,
  input  logic             r,
  input  logic             clear,
  input  logic             en,
  input  logic             tick,
  input  logic             hit,
  output logic [WIN_W-1:0] hits,
  output logic             full
);

  logic [WIN_W-1:0] winCnt;
  logic             step;

  // Counting stops at WINDOW, so neither counter can pass it.
  assign step = en && tick && (winCnt != WIN_W'(WINDOW));
  assign full = step && (winCnt == WIN_W'(WINDOW - 1));

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      winCnt <= '0;
      hits   <= '0;
    end else if (clear) begin
      winCnt <= '0;
      hits   <= '0;
    end else if (step) begin
      winCnt <= winCnt + WIN_W'(1);
      if (hit) hits <= hits + WIN_W'(1);
    end
  end

endmodule

// File: rtl/rock_regelaar.sv
// Rocking-intensity controller: steps rock_level per observation window and drives the motor.
// Optional sticky stress alarm under `ROCK_ALARM_EN; dbgState exposes the FSM state.
// tick is a one-way strobe with no ready: consumed in OBSERVE, silently dropped in any other state.
module rock_regelaar
  import rock_pkg::*;
#(
  parameter int LEVEL_W      = 3,
  parameter int MAX_LEVEL    = 7,
  parameter int START_LEVEL  = 3,
  parameter int WINDOW       = 16,
  parameter int THRESH       = 4,
  parameter int CALM_WINDOWS = 2
`ifdef ROCK_ALARM_EN
  ,
  parameter int FAIL_LIMIT   = 3
`endif
) (
  input  logic               clk,
  input  logic               r,
  input  logic               start,
  input  logic               stop,
  input  logic               tick,
  input  logic               stressLaag,
  output logic [LEVEL_W-1:0] rock_level,
  output logic               motor_en,
  output logic               calm,
  output logic               window_done,
  output logic               alarm,
  output rock_state_t        dbgState
);

  localparam int WIN_W  = cntWidth(WINDOW);
  localparam int GOOD_W = cntWidth(CALM_WINDOWS);

  rock_state_t        state, stateN;
  rock_outcome_t      outcome;
  logic [LEVEL_W-1:0] levelN;
  logic               motorN, calmN, doneN;
  logic [GOOD_W-1:0]  goodCnt, goodN;
  logic [WIN_W-1:0]   hits;
  logic               winFull, cntClear;

`ifdef ROCK_ALARM_EN
  localparam int FAIL_W = cntWidth(FAIL_LIMIT);
  logic [FAIL_W-1:0] failCnt, failN;
  logic              alarmQ, alarmN;
  assign alarm = alarmQ;
`else
  assign alarm = 1'b0;
`endif

  assign dbgState = state;
  assign cntClear = stop || (state == DECIDE) || (((state == IDLE) || (state == CALM)) && start);

  rock_venster #(
    .WINDOW(WINDOW),
    .WIN_W (WIN_W)
  ) uVenster (
    .clk  (clk),
    .r    (r),
    .clear(cntClear),
    .en   (state == OBSERVE),
    .tick (tick),
    .hit  (stressLaag),
    .hits (hits),
    .full (winFull)
  );

  always_comb begin
    stateN  = state;
    levelN  = rock_level;
    motorN  = motor_en;
    calmN   = calm;
    doneN   = 1'b0;
    goodN   = goodCnt;
`ifdef ROCK_ALARM_EN
    failN   = failCnt;
    alarmN  = alarmQ;
`endif
    outcome = (hits >= WIN_W'(THRESH)) ? GOOD : FAIL;
    if (stop) begin
      stateN = IDLE;
      levelN = '0;
      motorN = 1'b0;
      calmN  = 1'b0;
      goodN  = '0;
`ifdef ROCK_ALARM_EN
      failN  = '0;
      alarmN = 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, CALM: begin
          if (start) begin
            stateN = OBSERVE;
            levelN = LEVEL_W'(START_LEVEL);
            motorN = 1'b1;
            calmN  = 1'b0;
            goodN  = '0;
`ifdef ROCK_ALARM_EN
            failN  = '0;
`endif
          end
        end
        OBSERVE: begin
          if (winFull) begin
            stateN = DECIDE;
            doneN  = 1'b1;
          end
        end
        DECIDE: begin
          stateN = OBSERVE;
          if (outcome == GOOD) begin
            goodN = goodCnt + GOOD_W'(1);
`ifdef ROCK_ALARM_EN
            failN = '0;
`endif
            if (goodCnt == GOOD_W'(CALM_WINDOWS - 1)) begin
              goodN = '0;
              if (rock_level != '0) levelN = rock_level - LEVEL_W'(1);
              if (rock_level <= LEVEL_W'(1)) begin
                stateN = CALM;
                motorN = 1'b0;
                calmN  = 1'b1;
              end
            end
          end else begin
            goodN = '0;
            if (rock_level < LEVEL_W'(MAX_LEVEL)) begin
              levelN = rock_level + LEVEL_W'(1);
            end
`ifdef ROCK_ALARM_EN
            // Only windows already failed at full intensity count toward the alarm.
            else if (failCnt < FAIL_W'(FAIL_LIMIT)) begin
              failN = failCnt + FAIL_W'(1);
            end
            if (failN == FAIL_W'(FAIL_LIMIT)) alarmN = 1'b1;
`endif
          end
        end
        default: stateN = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state       <= IDLE;
      rock_level  <= '0;
      motor_en    <= 1'b0;
      calm        <= 1'b0;
      window_done <= 1'b0;
      goodCnt     <= '0;
`ifdef ROCK_ALARM_EN
      failCnt     <= '0;
      alarmQ      <= 1'b0;
`endif
    end else begin
      state       <= stateN;
      rock_level  <= levelN;
      motor_en    <= motorN;
      calm        <= calmN;
      window_done <= doneN;
      goodCnt     <= goodN;
`ifdef ROCK_ALARM_EN
      failCnt     <= failN;
      alarmQ      <= alarmN;
`endif
    end
  end

endmodule

// File: tb/tb_rock_regelaar.sv
// Self-checking bench for rock_regelaar: directed scenarios plus random traffic against a window-level model.
module tb_rock_regelaar;
  import rock_pkg::*;

  localparam int LEVEL_W      = 3;
  localparam int MAX_LEVEL    = 7;
  localparam int START_LEVEL  = 3;
  localparam int WINDOW       = 16;
  localparam int THRESH       = 4;
  localparam int CALM_WINDOWS = 2;
  localparam int FAIL_LIMIT   = 3;
`ifdef ROCK_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic r = 1'b1;
  logic start = 1'b0, stop = 1'b0, tick = 1'b0, stressLaag = 1'b0;
  logic [LEVEL_W-1:0] rock_level;
  logic motor_en, calm, window_done, alarm;
  rock_state_t dbgState;

  always #5 clk = ~clk;

  rock_regelaar dut (
    .clk        (clk),
    .r          (r),
    .start      (start),
    .stop       (stop),
    .tick       (tick),
    .stressLaag (stressLaag),
    .rock_level (rock_level),
    .motor_en   (motor_en),
    .calm       (calm),
    .window_done(window_done),
    .alarm      (alarm),
    .dbgState   (dbgState)
  );

  int n_checks = 0;
  int n_pass = 0;
  int done_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Session-level view: which phase we are in, how many ticks/hits the running
  // window has seen, and the level/calm/alarm bookkeeping applied per window.
  rock_state_t m_phase = IDLE;
  int m_level = 0, m_ticks = 0, m_hits = 0, m_goods = 0, m_fails = 0;
  bit m_motor = 0, m_calm = 0, m_done = 0, m_alarm = 0;

  always @(posedge clk or posedge r) begin
    if (r) begin
      m_phase = IDLE; m_level = 0; m_ticks = 0; m_hits = 0; m_goods = 0; m_fails = 0;
      m_motor = 0; m_calm = 0; m_done = 0; m_alarm = 0;
    end else begin
      m_done = 0;
      if (stop) begin
        m_phase = IDLE; m_level = 0; m_ticks = 0; m_hits = 0; m_goods = 0; m_fails = 0;
        m_motor = 0; m_calm = 0; m_alarm = 0;
      end else if (m_phase == IDLE || m_phase == CALM) begin
        if (start) begin
          m_phase = OBSERVE; m_level = START_LEVEL; m_motor = 1; m_calm = 0;
          m_ticks = 0; m_hits = 0; m_goods = 0; m_fails = 0;
        end
      end else if (m_phase == OBSERVE) begin
        if (tick) begin
          m_ticks++;
          m_hits += int'(stressLaag);
          if (m_ticks == WINDOW) begin
            m_phase = DECIDE;
            m_done = 1;
          end
        end
      end else begin
        m_phase = OBSERVE;
        if (m_hits >= THRESH) begin
          m_fails = 0;
          m_goods++;
          if (m_goods == CALM_WINDOWS) begin
            m_goods = 0;
            m_level = (m_level > 0) ? m_level - 1 : 0;
            if (m_level == 0) begin
              m_phase = CALM; m_motor = 0; m_calm = 1;
            end
          end
        end else begin
          m_goods = 0;
          if (m_level == MAX_LEVEL) begin
            if (ALARM_ON && m_fails < FAIL_LIMIT) m_fails++;
          end else begin
            m_level++;
          end
          if (ALARM_ON && m_fails == FAIL_LIMIT) m_alarm = 1;
        end
        m_ticks = 0;
        m_hits = 0;
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    check("rock_level", int'(rock_level), m_level);
    check("motor_en", int'(motor_en), int'(m_motor));
    check("calm", int'(calm), int'(m_calm));
    check("window_done", int'(window_done), int'(m_done));
    check("alarm", int'(alarm), int'(m_alarm));
    check("state", int'(dbgState), int'(m_phase));
    if (window_done) done_seen++;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  task automatic send_tick(input bit h);
    tick = 1'b1; stressLaag = h;
    @(negedge clk);
    tick = 1'b0; stressLaag = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic send_window(input int k);
    for (int i = 0; i < WINDOW; i++) send_tick(i < k);
  endtask

  task automatic restart();
    pulse_stop();
    pulse_start();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_level", int'(rock_level), 0);
    check("reset_motor", int'(motor_en), 0);
    check("reset_calm", int'(calm), 0);
    check("reset_done", int'(window_done), 0);
    check("reset_alarm", int'(alarm), 0);
    r = 1'b0;
    @(negedge clk);

    // Two all-hit windows: one step down after the second decision.
    pulse_start();
    check("t1_start_level", int'(rock_level), 3);
    done_seen = 0;
    send_window(16);
    check("t1_after_w1", int'(rock_level), 3);
    send_window(16);
    check("t1_done_pulses", done_seen, 2);
    check("t1_level", int'(rock_level), 2);

    // Threshold edge: 3 hits fails, 4 hits is good.
    restart();
    send_window(THRESH - 1);
    check("thr_minus1", int'(rock_level), 4);
    send_window(THRESH);
    check("thr_first_good", int'(rock_level), 4);
    send_window(THRESH);
    check("thr_second_good", int'(rock_level), 3);

    // Failed windows climb and saturate.
    restart();
    send_window(0);
    check("t2_first_fail", int'(rock_level), 4);
    repeat (5) send_window(0);
    check("t2_saturate", int'(rock_level), 7);

    // Calm down to zero, then restart.
    restart();
    repeat (4) send_window(WINDOW);
    check("t3_level1", int'(rock_level), 1);
    repeat (2) send_window(WINDOW);
    check("t3_level0", int'(rock_level), 0);
    check("t3_motor", int'(motor_en), 0);
    check("t3_calm", int'(calm), 1);
    pulse_start();
    check("t3_restart_level", int'(rock_level), 3);
    check("t3_restart_calm", int'(calm), 0);
    check("t3_restart_motor", int'(motor_en), 1);

    // Asynchronous reset between edges mid-window.
    repeat (5) send_tick(1'b1);
    #2 r = 1'b1;
    #1;
    check("t4_level", int'(rock_level), 0);
    check("t4_motor", int'(motor_en), 0);
    check("t4_calm", int'(calm), 0);
    @(negedge clk);
    r = 1'b0;
    @(negedge clk);
    check("t4_idle", int'(dbgState), int'(IDLE));

    // start+stop together in IDLE; stop during DECIDE.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("t5_both_idle", int'(dbgState), int'(IDLE));
    check("t5_both_level", int'(rock_level), 0);
    pulse_start();
    repeat (WINDOW - 1) send_tick(1'b1);
    tick = 1'b1; stressLaag = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("t5_decide_done", int'(window_done), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t5_stop_done", int'(window_done), 0);
    check("t5_stop_state", int'(dbgState), int'(IDLE));
    check("t5_stop_level", int'(rock_level), 0);

    // Alarm: 4 fails to reach 7, FAIL_LIMIT more at 7.
    pulse_start();
    repeat (4 + FAIL_LIMIT) send_window(0);
    check("t6_level", int'(rock_level), 7);
    check("t6_alarm", int'(alarm), int'(ALARM_ON));
    send_window(WINDOW);
    check("t6_alarm_sticky", int'(alarm), int'(ALARM_ON));
    pulse_stop();
    check("t6_alarm_cleared", int'(alarm), 0);

    // Random traffic: hit probability re-drawn every 16 operations.
    begin
      int p;
      int sel;
      p = 50;
      for (int i = 0; i < 2500; i++) begin
        if (i % 16 == 0) p = $urandom_range(0, 100);
        sel = $urandom_range(0, 199);
        if (sel < 2) pulse_stop();
        else if (sel < 3) begin
          start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
        end
        else if (sel < 10) pulse_start();
        else begin
          send_tick($urandom_range(0, 99) < p);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
